hilo_div_ctrl: RTL and testbench
================================

# hilo_div_ctrl

Multi-cycle divide controller that owns the HI/LO register pair. It accepts a divide request from the execute stage and runs a 32-iteration restoring division, signed or unsigned. It raises `busy` so the pipeline stalls, then commits quotient to LO and remainder to HI. It replaces the single-cycle combinational divide path with a sequenced, area-cheap iterative datapath and also services direct HI/LO writes.

## Interface
- `DIV_ITER`, 32: number of restoring iterations; must equal operand width.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `s`  in  `ALU_SELECTION_WIDTH`  operation; `div_op` = signed, `divu_op` = unsigned; any other value with `start` is ignored.
- `a`, `b`  in  32 each  dividend and divisor; captured on the accepting edge.
- `flush`  in  1  abort in-flight divide.
- `hi_we`, `lo_we`  in  1 each  direct write enables (mthi/mtlo).
- `wdata`  in  32  direct write data.
- `busy`  out  1  state != IDLE; the pipeline stalls on it.
- `done`  out  1  one-cycle pulse; HI/LO hold the new result.
- `hi`, `lo`  out  32 each  architectural HI/LO registers.

## Operation
- Reset (`rst`=0, asynchronous): state IDLE; `hi`=`lo`=0, `busy`=0, `done`=0; internal counter, remainder and quotient registers cleared.
- States:
  - IDLE: on `start` with a divide op, capture `a`/`b`/sign mode and go to PREP.
  - PREP: take magnitudes if signed; record `qneg`=a[31]^b[31] and `rneg`=a[31] (both 0 if unsigned). If divisor is 0, go to FIX with zero flag set; otherwise clear remainder, load quotient register with |a|, count=0, go to RUN.
  - RUN: one `div_step` per cycle, count increments; after iteration DIV_ITER-1 go to FIX.
  - FIX: apply signs and write `lo`=quotient and `hi`=remainder; `done`=1 next cycle; return to IDLE.
- Restoring step: {rem,quo} shifted left 1; trial = rem − |b| in 33 bits; if non-negative, rem=trial and quo LSB=1.
- Signed negation is two's complement mod 2^32. INT_MIN / −1 therefore gives lo=0x8000_0000, hi=0 with no trap.
- Divide by zero: lo=0xFFFF_FFFF, hi=captured `a` (unsigned and signed alike).
- `flush` in any non-IDLE state: IDLE next edge, HI/LO unchanged, no `done`. `flush` in IDLE has no effect.
- `start` while busy: ignored. `start` with a non-divide op: ignored.
- `hi_we`/`lo_we`: take effect only in IDLE and are ignored while busy. If they coincide with an accepted `start`, the write happens and the later divide result overwrites it.
- Operands are registered at acceptance; changes on `a`/`b` during busy have no effect.

## Timing
- Let T be the edge that samples `start` in IDLE.
- Non-zero divisor:
  - T: enter PREP.
  - T+1: enter RUN.
  - T+2..T+33: iterations.
  - T+33: enter FIX.
  - T+34: `hi`/`lo` updated, `done`=1, state IDLE.
  - `busy` high from T to T+34 (34 cycles); `done` high from T+34 to T+35.
  - Earliest next accept is edge T+35.
- Zero divisor: PREP at T, FIX at T+1, commit and `done` at T+2 (busy 2 cycles).
- `busy` is decoded from the state register, so it is glitch-free and valid in the cycle after T.
- Direct writes are visible on `hi`/`lo` the cycle after the write edge.

## Structure
- `div_op`, `divu_op`, `ALU_SELECTION_WIDTH` and the state encodings (IDLE, PREP, RUN, FIX) live in the shared macro file `Marco.v`.
- Sub-module `div_step`: purely combinational one-iteration restoring step. Inputs are rem[31:0], quo[31:0], divisor[31:0]; outputs are next rem and next quo.
- Control FSM, 6-bit counter, sign fix-up and HI/LO registers stay in `hilo_div_ctrl`.

## Test plan
- Unsigned: start, divu_op, a=100, b=7 → busy 34 cycles; at T+34 lo=14, hi=2, done single pulse.
- Signed: div_op, a=−7 (0xFFFF_FFF9), b=2 → lo=0xFFFF_FFFD (−3), hi=0xFFFF_FFFF (−1); also a=0x8000_0000, b=0xFFFF_FFFF → lo=0x8000_0000, hi=0.
- Divide by zero: divu_op, a=0x1234, b=0 → done at T+2, lo=0xFFFF_FFFF, hi=0x1234.
- Flush and reset: preload hi=0xAAAA_AAAA via hi_we; start a divide and assert flush at T+10 → IDLE at T+11, hi still 0xAAAA_AAAA, no done. In a separate run, drop rst mid-RUN → all outputs 0 immediately.
- Ignored inputs: start and lo_we=1 with wdata=5 at T+5 during busy → no restart, lo unchanged until the T+34 commit; a start with add_op in IDLE leaves busy=0.
- Back-to-back: second start held high from T+34 → accepted at T+35, second result at T+69.

Source files
------------

// File: rtl/hilo_div_ctrl_pkg.sv
// Shared ALU selection codes, divider FSM encodings and
// small helpers for the HI/LO divide controller.
package hilo_div_ctrl_pkg;

  localparam int ALU_SELECTION_WIDTH = 4;

  localparam logic [ALU_SELECTION_WIDTH-1:0] add_op  = 4'd0;
  localparam logic [ALU_SELECTION_WIDTH-1:0] sub_op  = 4'd1;
  localparam logic [ALU_SELECTION_WIDTH-1:0] and_op  = 4'd2;
  localparam logic [ALU_SELECTION_WIDTH-1:0] or_op   = 4'd3;
  localparam logic [ALU_SELECTION_WIDTH-1:0] xor_op  = 4'd4;
  localparam logic [ALU_SELECTION_WIDTH-1:0] slt_op  = 4'd5;
  localparam logic [ALU_SELECTION_WIDTH-1:0] mult_op = 4'd6;
  localparam logic [ALU_SELECTION_WIDTH-1:0] multu_op = 4'd7;
  localparam logic [ALU_SELECTION_WIDTH-1:0] div_op  = 4'd8;
  localparam logic [ALU_SELECTION_WIDTH-1:0] divu_op = 4'd9;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PREP = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] FIX  = 2'd3;

  function automatic logic [31:0] neg_if(
    input logic        c,
    input logic [31:0] v
  );
    return c ? (~v + 32'd1) : v;
  endfunction

  function automatic logic is_div_sel(
    input logic [ALU_SELECTION_WIDTH-1:0] sel
  );
    return (sel == div_op) || (sel == divu_op);
  endfunction

endpackage

// File: rtl/hilo_div_ctrl_step.sv
// One restoring-division iteration: shift {rem,quo} left,
// trial-subtract the divisor and keep it when non-negative.
module div_step
  import hilo_div_ctrl_pkg::*;
(
  input  logic [31:0] rem_i,
  input  logic [31:0] quo_i,
  input  logic [31:0] dvs_i,
  output logic [31:0] rem_o,
  output logic [31:0] quo_o
);

  logic [32:0] rem_sh;
  logic [32:0] trial;

  // 33-bit trial: bit 32 set means the subtraction borrowed
  always_comb begin
    rem_sh = {rem_i, quo_i[31]};
    trial  = rem_sh - {1'b0, dvs_i};
    if (!trial[32]) begin
      rem_o = trial[31:0];
      quo_o = {quo_i[30:0], 1'b1};
    end else begin
      rem_o = rem_sh[31:0];
      quo_o = {quo_i[30:0], 1'b0};
    end
  end

endmodule

// File: rtl/hilo_div_ctrl.sv
// Iterative restoring divider that owns HI/LO: sequences
// PREP/RUN/FIX, applies signs and services mthi/mtlo.
module hilo_div_ctrl
  import hilo_div_ctrl_pkg::*;
#(
  parameter int DIV_ITER = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [ALU_SELECTION_WIDTH-1:0] s,
  input  logic [31:0]                    a,
  input  logic [31:0]                    b,
  input  logic                           flush,
  input  logic                           hi_we,
  input  logic                           lo_we,
  input  logic [31:0]                    wdata,
  output logic                           busy,
  output logic                           done,
  output logic [31:0]                    hi,
  output logic [31:0]                    lo
);

  localparam logic [5:0] LAST = 6'(DIV_ITER - 1);

  logic [1:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        sgn_q, sgn_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic        zero_q, zero_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic [31:0] step_rem;
  logic [31:0] step_quo;
  logic [31:0] mag_a;
  logic [31:0] mag_b;

  div_step u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  always_comb begin
    mag_a = neg_if(sgn_q & a_q[31], a_q);
    mag_b = neg_if(sgn_q & b_q[31], b_q);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    zero_d  = zero_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start && is_div_sel(s)) begin
          a_d     = a;
          b_d     = b;
          sgn_d   = (s == div_op);
          state_d = PREP;
        end
      end
      PREP: begin
        qneg_d = sgn_q & (a_q[31] ^ b_q[31]);
        rneg_d = sgn_q & a_q[31];
        dvs_d  = mag_b;
        zero_d = (b_q == 32'd0);
        if (b_q == 32'd0) begin
          state_d = FIX;
        end else begin
          rem_d   = 32'd0;
          quo_d   = mag_a;
          cnt_d   = 6'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == LAST) state_d = FIX;
      end
      FIX: begin
        if (zero_q) begin
          lo_d = 32'hFFFF_FFFF;
          hi_d = a_q;
        end else begin
          lo_d = neg_if(qneg_q, quo_q);
          hi_d = neg_if(rneg_q, rem_q);
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // abort wins over a same-cycle commit
    if (flush && (state_q != IDLE)) begin
      state_d = IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      sgn_q   <= 1'b0;
      dvs_q   <= 32'd0;
      rem_q   <= 32'd0;
      quo_q   <= 32'd0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      zero_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      zero_q  <= zero_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Randomised self-checking bench for hilo_div_ctrl against
// an arithmetic model of HI/LO divide semantics.
module tb_hilo_div_ctrl;
  import hilo_div_ctrl_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  s;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int errs;
  int checks;

  logic [31:0] m_hi;
  logic [31:0] m_lo;

  hilo_div_ctrl #(.DIV_ITER(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .s     (s),
    .a     (a),
    .b     (b),
    .flush (flush),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic ref_div(
    input  logic [3:0]  op,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic [31:0] q,
    output logic [31:0] r
  );
    longint sx;
    longint sy;
    longint lq;
    longint lr;
    if (y == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = x;
    end else if (op == div_op) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      lq = sx / sy;
      lr = sx % sy;
      q  = lq[31:0];
      r  = lr[31:0];
    end else begin
      q = x / y;
      r = x % y;
    end
  endtask

  // accept at edge T, then count edges until done
  task automatic do_div(
    input string       tag,
    input logic [3:0]  op,
    input logic [31:0] x,
    input logic [31:0] y
  );
    int n;
    int nb;
    logic [31:0] q;
    logic [31:0] r;
    ref_div(op, x, y, q, r);
    @(negedge clk);
    start = 1'b1;
    s = op;
    a = x;
    b = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    n = 0;
    nb = 0;
    while (!done && n < 100) begin
      if (busy) nb++;
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_lat"}, 32'(n), (y == 0) ? 32'd2 : 32'd34);
    chk({tag, "_busy"}, 32'(nb), (y == 0) ? 32'd2 : 32'd34);
    chk({tag, "_lo"}, lo, q);
    chk({tag, "_hi"}, hi, r);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    m_lo = q;
    m_hi = r;
    @(posedge clk);
    #1;
    chk({tag, "_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int n;
    int seen;
    logic [3:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] q;
    logic [31:0] r;
    logic [31:0] q2;
    logic [31:0] r2;

    errs = 0;
    checks = 0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    rst = 1'b0;
    start = 1'b0;
    s = add_op;
    a = 32'd0;
    b = 32'd0;
    flush = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    wdata = 32'd0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    do_div("divu_100_7", divu_op, 32'd100, 32'd7);
    do_div("div_m7_2", div_op, 32'hFFFF_FFF9, 32'd2);
    do_div("div_min_m1", div_op, 32'h8000_0000, 32'hFFFF_FFFF);
    do_div("divu_zero", divu_op, 32'h1234, 32'd0);
    do_div("div_zero", div_op, 32'h8765_4321, 32'd0);
    do_div("divu_max", divu_op, 32'hFFFF_FFFF, 32'd1);

    for (int i = 0; i < 24; i++) begin
      op = $urandom_range(0, 1) ? div_op : divu_op;
      x = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1, 2: y = 32'($urandom_range(1, 15));
        3: y = -32'($urandom_range(1, 15));
        default: y = $urandom;
      endcase
      do_div("rnd", op, x, y);
    end

    // direct writes
    @(negedge clk);
    hi_we = 1'b1;
    wdata = 32'hAAAA_AAAA;
    @(negedge clk);
    hi_we = 1'b0;
    lo_we = 1'b1;
    wdata = 32'h5555_1234;
    @(negedge clk);
    lo_we = 1'b0;
    m_hi = 32'hAAAA_AAAA;
    m_lo = 32'h5555_1234;
    chk("mthi", hi, m_hi);
    chk("mtlo", lo, m_lo);

    // flush mid-run: no commit, no done
    @(negedge clk);
    start = 1'b1;
    s = divu_op;
    a = 32'd1000;
    b = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_busy", 32'(busy), 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) seen++;
      @(posedge clk);
      #1;
    end
    chk("flush_nodone", 32'(seen), 32'd0);
    chk("flush_hi", hi, m_hi);
    chk("flush_lo", lo, m_lo);

    // flush in IDLE does nothing
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("idle_flush_hi", hi, m_hi);

    // non-divide start ignored
    @(negedge clk);
    start = 1'b1;
    s = add_op;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("addop_busy", 32'(busy), 32'd0);

    // start + lo_we during busy ignored
    ref_div(divu_op, 32'd5000, 32'd13, q, r);
    @(negedge clk);
    start = 1'b1;
    s = divu_op;
    a = 32'd5000;
    b = 32'd13;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1;
    s = div_op;
    a = 32'd77;
    b = 32'd0;
    lo_we = 1'b1;
    hi_we = 1'b1;
    wdata = 32'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    lo_we = 1'b0;
    hi_we = 1'b0;
    chk("busy_lo_hold", lo, m_lo);
    n = 5;
    while (!done && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("ign_lat", 32'(n), 32'd34);
    chk("ign_lo", lo, q);
    chk("ign_hi", hi, r);
    m_lo = q;
    m_hi = r;
    @(posedge clk);
    #1;
    chk("ign_norestart", 32'(busy), 32'd0);

    // back-to-back with start held across commit
    ref_div(div_op, 32'hFFFF_FC18, 32'd7, q, r);
    ref_div(divu_op, 32'hDEAD_BEEF, 32'd255, q2, r2);
    @(negedge clk);
    start = 1'b1;
    s = div_op;
    a = 32'hFFFF_FC18;
    b = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (32) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    s = divu_op;
    a = 32'hDEAD_BEEF;
    b = 32'd255;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("b2b_done1", 32'(done), 32'd1);
    chk("b2b_lo1", lo, q);
    chk("b2b_hi1", hi, r);
    @(posedge clk);
    #1;
    chk("b2b_acc2", 32'(busy), 32'd1);
    start = 1'b0;
    n = 35;
    while (!done && n < 150) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("b2b_lat2", 32'(n), 32'd69);
    chk("b2b_lo2", lo, q2);
    chk("b2b_hi2", hi, r2);

    // async reset mid-run clears everything at once
    @(negedge clk);
    start = 1'b1;
    s = divu_op;
    a = 32'd999;
    b = 32'd4;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    m_hi = 32'd0;
    m_lo = 32'd0;

    do_div("post_rst", div_op, 32'd7, 32'hFFFF_FFFE);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
